idiv_iter: RTL

IDIV_ITER -- requirements
Module: idiv_iter

---
 rtl/idiv_iter_pkg.sv | 26 ++
 rtl/idiv_iter_if.sv | 31 +++
 rtl/idiv_iter_div_step.sv | 25 ++
 rtl/idiv_iter.sv | 116 +++++++++++
 4 files changed

// File: rtl/idiv_iter_pkg.sv
// Shared backend types for the iterative integer divider: operation encodings,
// FSM state encoding and small op-decoding helpers.
package idiv_iter_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic logic op_is_signed(div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic op_is_rem(div_op_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/idiv_iter_if.sv
// Request/result bus of the iterative divider. Both channels use valid/ready:
// a transfer happens on a rising clock edge where valid and ready are both 1.
interface idiv_iter_if
  import idiv_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) ();

  logic             in_valid;
  logic             in_ready;
  div_op_t          in_op;
  logic [XLEN-1:0]  in1;
  logic [XLEN-1:0]  in2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in1, in2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in1, in2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/idiv_iter_div_step.sv
// One restoring radix-2 division step on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, subtract the divisor if it fits.
module idiv_iter_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          q_bit;

  assign rem_sh = {rem_in, quo_in[XLEN-1]};
  assign diff   = rem_sh - {1'b0, divisor};
  // A set top bit means the shifted remainder exceeds any XLEN-bit divisor;
  // this keeps divide-by-zero producing all-ones and remainder = dividend.
  assign q_bit   = rem_sh[XLEN] | ~diff[XLEN];
  assign rem_out = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], q_bit};

endmodule

// File: rtl/idiv_iter.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC.
module idiv_iter
  import idiv_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  idiv_iter_if.slave bus,
  output logic       busy,
  output div_state_t dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  div_op_t          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_a_q, neg_b_q, zero_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, res_q;
  logic [XLEN-1:0]  rem_nx, quo_nx, quo_fix, rem_fix, calc_res;
  logic             in_signed, in_zero, accept, last_step, fast;
  logic [XLEN-1:0]  fast_res;

  assign in_signed    = op_is_signed(bus.in_op);
  assign in_zero      = (bus.in2 == '0);
  assign bus.in_ready = reset && !flush && (state_q == ST_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_step    = (state_q == ST_CALC) && (cnt_q == '0);

`ifdef DIV_FASTPATH_EN
  logic in_ovf;
  assign in_ovf = in_signed && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
  assign fast   = in_zero || in_ovf;
  always_comb begin
    fast_res = '0;
    if (in_zero)     fast_res = op_is_rem(bus.in_op) ? bus.in1 : '1;
    else if (in_ovf) fast_res = op_is_rem(bus.in_op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  idiv_iter_div_step #(.XLEN(XLEN)) div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Sign restore on the final step; a zero divisor keeps the all-ones quotient.
  assign quo_fix  = ((neg_a_q ^ neg_b_q) && !zero_q) ? -quo_nx : quo_nx;
  assign rem_fix  = neg_a_q ? -rem_nx : rem_nx;
  assign calc_res = op_is_rem(op_q) ? rem_fix : quo_fix;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      op_q    <= DIV_DIV;
      tag_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zero_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      res_q   <= '0;
    end else if (accept) begin
      op_q    <= bus.in_op;
      tag_q   <= bus.in_tag;
      neg_a_q <= in_signed && bus.in1[XLEN-1];
      neg_b_q <= in_signed && bus.in2[XLEN-1];
      zero_q  <= in_zero;
      cnt_q   <= CNT_LOAD;
      rem_q   <= '0;
      quo_q   <= (in_signed && bus.in1[XLEN-1]) ? -bus.in1 : bus.in1;
      dvsr_q  <= (in_signed && bus.in2[XLEN-1]) ? -bus.in2 : bus.in2;
      if (fast) res_q <= fast_res;
    end else if (state_q == ST_CALC) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (last_step) res_q <= calc_res;
      else           cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = bus.out_valid ? res_q : '0;
  assign bus.out_tag   = tag_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule
